// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PRI_NONE = 2'd0,
        PRI_BR   = 2'd1,
        PRI_ERET = 2'd2,
        PRI_EXC  = 2'd3
    } pri_e;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0004;

    localparam int unsigned ALIGN_W = 64;
    typedef logic [ALIGN_W-1:0] align_t;

    // inc must be a power of two; clears its low log2(inc) bits.
    function automatic align_t align(input align_t addr,
                                     input int unsigned inc);
        return addr & ~(align_t'(inc) - align_t'(1));
    endfunction

endpackage

// File: rtl/pc_unit_pending_slot.sv
// One-entry redirect buffer used while fetch is stalled.
module pc_pending_slot
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  pri_e             req_pri,
    input  logic [WIDTH-1:0] req_tgt,
    output logic             accept,
    output logic             valid,
    output logic [WIDTH-1:0] tgt
);

    pri_e pri;

    // An empty slot holds PRI_NONE, so any real request wins against it.
    assign accept = (req_pri != PRI_NONE) && (req_pri >= pri);
    assign valid  = (pri != PRI_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri <= PRI_NONE;
            tgt <= '0;
        end else if (ena) begin
            pri <= PRI_NONE;
            tgt <= '0;
        end else if (accept) begin
            pri <= req_pri;
            tgt <= req_tgt;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with redirect arbitration, EPC and EXL.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
    parameter int unsigned      INC       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_epc,
    input  logic             eret_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             exl,
    output logic             pend_valid
);

    function automatic logic [WIDTH-1:0] al(input logic [WIDTH-1:0] a);
        return WIDTH'(align(align_t'(a), INC));
    endfunction

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(align(align_t'(RESET_VEC), INC));
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(align(align_t'(EXC_VEC), INC));

    pri_e             req_pri;
    logic [WIDTH-1:0] req_tgt;
    logic             accept;
    logic [WIDTH-1:0] pend_tgt;
    logic [WIDTH-1:0] pc_nxt;

    assign pc_plus = pc + WIDTH'(INC);

    always_comb begin
        req_pri = PRI_NONE;
        req_tgt = '0;
        priority case (1'b1)
            exc_valid: begin
                req_pri = PRI_EXC;
                req_tgt = EXC_PC;
            end
            eret_valid: begin
                req_pri = PRI_ERET;
                req_tgt = al(epc);
            end
            br_valid: begin
                req_pri = PRI_BR;
                req_tgt = al(br_target);
            end
            default: begin
                req_pri = PRI_NONE;
                req_tgt = '0;
            end
        endcase
    end

    pc_pending_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req_pri (req_pri),
        .req_tgt (req_tgt),
        .accept  (accept),
        .valid   (pend_valid),
        .tgt     (pend_tgt)
    );

    // A request losing to the pending entry is dropped, side effects too.
    always_comb begin
        pc_nxt = pc_plus;
        if (accept) begin
            pc_nxt = req_tgt;
        end else if (pend_valid) begin
            pc_nxt = pend_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RST_PC;
        end else if (ena) begin
            pc <= pc_nxt;
        end
    end

    // Nested exceptions keep the first EPC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= '0;
            exl <= 1'b0;
        end else if (accept) begin
            if (req_pri == PRI_EXC) begin
                if (!exl) begin
                    epc <= exc_epc;
                end
                exl <= 1'b1;
            end else if (req_pri == PRI_ERET) begin
                exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit and a 16-bit instance.
module tb_pc_unit;

    logic        clk;
    logic        rst, ena, br_valid, exc_valid, eret_valid;
    logic [31:0] br_target, exc_epc;
    logic [31:0] pc, pc_plus, epc;
    logic        exl, pend_valid;

    logic        h_rst, h_ena, h_br_valid, h_exc_valid, h_eret_valid;
    logic [15:0] h_br_target, h_exc_epc;
    logic [15:0] h_pc, h_pc_plus, h_epc;
    logic        h_exl, h_pend_valid;

    int n_chk;
    int n_fail;

    pc_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_valid  (exc_valid),
        .exc_epc    (exc_epc),
        .eret_valid (eret_valid),
        .pc         (pc),
        .pc_plus    (pc_plus),
        .epc        (epc),
        .exl        (exl),
        .pend_valid (pend_valid)
    );

    pc_unit #(
        .WIDTH (16)
    ) u_dut16 (
        .clk        (clk),
        .rst        (h_rst),
        .ena        (h_ena),
        .br_valid   (h_br_valid),
        .br_target  (h_br_target),
        .exc_valid  (h_exc_valid),
        .exc_epc    (h_exc_epc),
        .eret_valid (h_eret_valid),
        .pc         (h_pc),
        .pc_plus    (h_pc_plus),
        .epc        (h_epc),
        .exl        (h_exl),
        .pend_valid (h_pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_valid   = 1'b0;
        exc_valid  = 1'b0;
        eret_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1; ena = 1'b0; idle();
        br_target = '0; exc_epc = '0;
        h_rst = 1'b1; h_ena = 1'b0;
        h_br_valid = 1'b0; h_exc_valid = 1'b0; h_eret_valid = 1'b0;
        h_br_target = '0; h_exc_epc = '0;

        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_exl", {31'd0, exl}, 32'h0);
        chk("rst_pend", {31'd0, pend_valid}, 32'h0);
        chk("rst_pc_plus", pc_plus, 32'h4);

        rst = 1'b0; ena = 1'b1;
        step(); chk("seq1", pc, 32'h4);
        step(); chk("seq2", pc, 32'h8);
        step(); chk("seq3", pc, 32'hC);
        chk("seq_exl", {31'd0, exl}, 32'h0);
        chk("seq_epc", epc, 32'h0);

        br_valid = 1'b1; br_target = 32'h100;
        step(); chk("br_100", pc, 32'h100);
        br_target = 32'h203;
        step(); chk("br_align", pc, 32'h200);
        idle();
        step(); chk("br_seq", pc, 32'h204);

        ena = 1'b0;
        br_valid = 1'b1; br_target = 32'h400;
        step();
        chk("stall_c1_pend", {31'd0, pend_valid}, 32'h1);
        chk("stall_c1_pc", pc, 32'h204);
        idle(); exc_valid = 1'b1; exc_epc = 32'h120;
        step();
        chk("stall_c2_epc", epc, 32'h120);
        chk("stall_c2_exl", {31'd0, exl}, 32'h1);
        idle();
        step();
        chk("stall_c3_pc", pc, 32'h204);
        chk("stall_c3_pend", {31'd0, pend_valid}, 32'h1);
        ena = 1'b1;
        step();
        chk("stall_rel_pc", pc, 32'h4);
        chk("stall_rel_pend", {31'd0, pend_valid}, 32'h0);

        step(); chk("after_exc_seq", pc, 32'h8);
        exc_valid = 1'b1; exc_epc = 32'h300;
        step();
        chk("nest_pc", pc, 32'h4);
        chk("nest_epc", epc, 32'h120);
        chk("nest_exl", {31'd0, exl}, 32'h1);
        idle(); eret_valid = 1'b1;
        step();
        chk("eret_pc", pc, 32'h120);
        chk("eret_exl", {31'd0, exl}, 32'h0);
        idle();
        step(); chk("eret_seq", pc, 32'h124);

        exc_valid = 1'b1; eret_valid = 1'b1; exc_epc = 32'h500;
        step();
        chk("both_pc", pc, 32'h4);
        chk("both_exl", {31'd0, exl}, 32'h1);
        chk("both_epc", epc, 32'h500);
        idle(); eret_valid = 1'b1;
        step();
        chk("eret2_pc", pc, 32'h500);
        chk("eret2_exl", {31'd0, exl}, 32'h0);

        ena = 1'b0;
        idle(); exc_valid = 1'b1; exc_epc = 32'h600;
        step();
        chk("pexc_epc", epc, 32'h600);
        idle(); eret_valid = 1'b1;
        step();
        chk("low_eret_exl", {31'd0, exl}, 32'h1);
        chk("low_eret_pc", pc, 32'h500);
        ena = 1'b1;
        idle();
        step(); chk("low_eret_rel", pc, 32'h4);

        eret_valid = 1'b1;
        step();
        chk("eret3_pc", pc, 32'h600);
        chk("eret3_exl", {31'd0, exl}, 32'h0);
        ena = 1'b0;
        idle(); exc_valid = 1'b1; exc_epc = 32'h700;
        step();
        ena = 1'b1;
        idle(); br_valid = 1'b1; br_target = 32'h800;
        step();
        chk("pend_beats_br", pc, 32'h4);
        chk("pend_beats_br_epc", epc, 32'h700);
        chk("pend_cleared", {31'd0, pend_valid}, 32'h0);
        idle();

        step();
        h_rst = 1'b0; h_ena = 1'b1;
        h_br_valid = 1'b1; h_br_target = 16'hFFFC;
        step();
        chk("w16_pc", {16'd0, h_pc}, 32'hFFFC);
        chk("w16_pc_plus", {16'd0, h_pc_plus}, 32'h0);
        h_br_valid = 1'b0;
        step();
        chk("w16_wrap", {16'd0, h_pc}, 32'h0);
        h_ena = 1'b0;
        h_br_valid = 1'b1; h_br_target = 16'h1234;
        step();
        chk("w16_pend", {16'd0, 15'd0, h_pend_valid}, 32'h1);
        h_br_valid = 1'b0;
        #1 h_rst = 1'b1;
        #1;
        chk("w16_arst_pc", {16'd0, h_pc}, 32'h0);
        chk("w16_arst_pend", {16'd0, 15'd0, h_pend_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
